// File: rtl/ysyx_22041071_axi_r_slave.sv
// AXI4 read-channel slave in front of a simple one-cycle-latency memory.
// One burst in flight at a time; each beat is a memory read followed by one R beat.
//
// Handshake rule: a transfer happens on a rising edge where valid and ready are both 1.
// A valid is never withdrawn before its transfer, and the payload it carries stays
// unchanged until then. axi_ar_ready_o and axi_r_valid_o come straight from the
// state register, so neither has a combinational path from any input.
module ysyx_22041071_axi_r_slave #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int ID_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  axi_ar_valid_i,
    output logic                  axi_ar_ready_o,
    input  logic [ID_WIDTH-1:0]   axi_ar_id_i,
    input  logic [ADDR_WIDTH-1:0] axi_ar_addr_i,
    input  logic [7:0]            axi_ar_len_i,
    input  logic [2:0]            axi_ar_size_i,
    input  logic [1:0]            axi_ar_burst_i,
    output logic                  axi_r_valid_o,
    input  logic                  axi_r_ready_i,
    output logic [ID_WIDTH-1:0]   axi_r_id_o,
    output logic [DATA_WIDTH-1:0] axi_r_data_o,
    output logic [1:0]            axi_r_resp_o,
    output logic                  axi_r_last_o,
    output logic                  axi_r_user_o,
    output logic                  mem_en_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;

    state_t                state;
    state_t                state_next;

    logic [ID_WIDTH-1:0]   id_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic                  err_q;
    logic [7:0]            beat_q;
    logic [DATA_WIDTH-1:0] data_q;

    logic                  ar_hs;
    logic                  r_hs;
    logic                  last_beat;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign ar_hs     = axi_ar_valid_i && (state == IDLE);
    assign r_hs      = axi_r_ready_i && (state == RESP);
    assign last_beat = (beat_q == len_q);

    // Address of the following beat: INCR aligns down to the beat size, then steps
    // by one beat (wrapping at the top of the address space); FIXED repeats.
    always_comb begin
        step      = {{(ADDR_WIDTH-1){1'b0}}, 1'b1} << size_q;
        next_addr = addr_q;
        case (burst_q)
            BURST_INCR:  next_addr = (addr_q & ~(step - 1'b1)) + step;
            BURST_FIXED: next_addr = addr_q;
            default:     next_addr = addr_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state: one memory read and one R beat per iteration until the last beat.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (axi_ar_valid_i) state_next = MREQ;
            MREQ:    state_next = MWAIT;
            MWAIT:   state_next = RESP;
            RESP:    if (axi_r_ready_i) state_next = last_beat ? IDLE : MREQ;
            default: state_next = IDLE;
        endcase
    end

    // Burst context, beat tracking and the registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            size_q  <= '0;
            burst_q <= '0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            data_q  <= '0;
        end else begin
            if (ar_hs) begin
                id_q    <= axi_ar_id_i;
                addr_q  <= axi_ar_addr_i;
                len_q   <= axi_ar_len_i;
                size_q  <= axi_ar_size_i;
                burst_q <= axi_ar_burst_i;
                // WRAP and the reserved burst type are not served, nor beats wider
                // than the 8-byte memory word; such bursts answer SLVERR on every beat.
                err_q   <= axi_ar_burst_i[1] || (axi_ar_size_i > 3'd3);
                beat_q  <= '0;
            end
            if (state == MWAIT) begin
                data_q <= err_q ? '0 : mem_rdata_i;
            end
            if (r_hs && !last_beat) begin
                beat_q <= beat_q + 8'd1;
                addr_q <= next_addr;
            end
        end
    end

    assign axi_ar_ready_o = (state == IDLE);
    assign axi_r_valid_o  = (state == RESP);
    assign axi_r_id_o     = id_q;
    assign axi_r_data_o   = data_q;
    assign axi_r_resp_o   = err_q ? 2'b10 : 2'b00;
    assign axi_r_last_o   = (state == RESP) && last_beat;
    assign axi_r_user_o   = 1'b0;
    assign mem_en_o       = (state == MREQ) && !err_q;
    assign mem_addr_o     = {addr_q[ADDR_WIDTH-1:3], 3'b000};

endmodule

// File: tb/tb_ysyx_22041071_axi_r_slave.sv
// Directed bench for the AXI read slave: memory model, driver tasks, and an
// expected-address queue fed by the stimulus and drained by a memory-port monitor.
module tb_ysyx_22041071_axi_r_slave;

    logic        clk;
    logic        reset;
    logic        axi_ar_valid_i;
    logic        axi_ar_ready_o;
    logic [3:0]  axi_ar_id_i;
    logic [63:0] axi_ar_addr_i;
    logic [7:0]  axi_ar_len_i;
    logic [2:0]  axi_ar_size_i;
    logic [1:0]  axi_ar_burst_i;
    logic        axi_r_valid_o;
    logic        axi_r_ready_i;
    logic [3:0]  axi_r_id_o;
    logic [63:0] axi_r_data_o;
    logic [1:0]  axi_r_resp_o;
    logic        axi_r_last_o;
    logic        axi_r_user_o;
    logic        mem_en_o;
    logic [63:0] mem_addr_o;
    logic [63:0] mem_rdata_i;

    int          chk_cnt = 0;
    int          err_cnt = 0;
    logic [63:0] exp_q[$];

    ysyx_22041071_axi_r_slave #(
        .ADDR_WIDTH(64),
        .DATA_WIDTH(64),
        .ID_WIDTH  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .axi_ar_valid_i(axi_ar_valid_i),
        .axi_ar_ready_o(axi_ar_ready_o),
        .axi_ar_id_i   (axi_ar_id_i),
        .axi_ar_addr_i (axi_ar_addr_i),
        .axi_ar_len_i  (axi_ar_len_i),
        .axi_ar_size_i (axi_ar_size_i),
        .axi_ar_burst_i(axi_ar_burst_i),
        .axi_r_valid_o (axi_r_valid_o),
        .axi_r_ready_i (axi_r_ready_i),
        .axi_r_id_o    (axi_r_id_o),
        .axi_r_data_o  (axi_r_data_o),
        .axi_r_resp_o  (axi_r_resp_o),
        .axi_r_last_o  (axi_r_last_o),
        .axi_r_user_o  (axi_r_user_o),
        .mem_en_o      (mem_en_o),
        .mem_addr_o    (mem_addr_o),
        .mem_rdata_i   (mem_rdata_i)
    );

    // Clock and reset defaults.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents as a function of the word address.
    function automatic logic [63:0] mem_word(input logic [63:0] a);
        if (a == 64'h0000_0000_8000_0000) return 64'h1122_3344_5566_7788;
        return {a[31:0] ^ 32'hA5A5_0000, a[31:0]};
    endfunction

    // Memory model: data valid only in the cycle right after the strobe.
    always @(posedge clk) begin
        if (mem_en_o) mem_rdata_i <= mem_word(mem_addr_o);
        else          mem_rdata_i <= 64'hBAD0_BAD0_BAD0_BAD0;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Every memory strobe must match the next expected word address.
    always @(negedge clk) begin
        if (mem_en_o === 1'b1) begin
            if (exp_q.size() == 0) check("mem_en_unexpected", {63'd0, mem_en_o}, 64'd0);
            else                   check("mem_addr", mem_addr_o, exp_q.pop_front());
        end
    end

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_ar_ready", {63'd0, axi_ar_ready_o}, 64'd1);
        check("rst_r_valid",  {63'd0, axi_r_valid_o},  64'd0);
        check("rst_r_last",   {63'd0, axi_r_last_o},   64'd0);
        check("rst_mem_en",   {63'd0, mem_en_o},       64'd0);
        check("rst_r_data",   axi_r_data_o,            64'd0);
        check("rst_r_id",     {60'd0, axi_r_id_o},     64'd0);
        check("rst_r_resp",   {62'd0, axi_r_resp_o},   64'd0);
        check("rst_mem_addr", mem_addr_o,              64'd0);
        check("rst_r_user",   {63'd0, axi_r_user_o},   64'd0);
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
        @(negedge clk);
        axi_ar_valid_i = 1'b1;
        axi_ar_id_i    = id;
        axi_ar_addr_i  = addr;
        axi_ar_len_i   = len;
        axi_ar_size_i  = size;
        axi_ar_burst_i = burst;
        check("ar_ready_idle", {63'd0, axi_ar_ready_o}, 64'd1);
        @(posedge clk);
        #1 axi_ar_valid_i = 1'b0;
    endtask

    // Waits for one R beat (3 cycles after the previous handshake), checks it,
    // holds off ready for bp cycles, then accepts it.
    task automatic wait_beat(input logic exp_mem, input logic [63:0] maddr, input logic [63:0] data,
                             input logic [3:0] id, input logic [1:0] resp, input logic last,
                             input int bp);
        int n;
        if (exp_mem) exp_q.push_back(maddr);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) check("mem_en_t1", {63'd0, mem_en_o}, {63'd0, exp_mem});
        end while (!axi_r_valid_o && n < 20);
        check("r_latency", 64'(n), 64'd3);
        check("r_data", axi_r_data_o, data);
        check("r_id",   {60'd0, axi_r_id_o},   {60'd0, id});
        check("r_resp", {62'd0, axi_r_resp_o}, {62'd0, resp});
        check("r_last", {63'd0, axi_r_last_o}, {63'd0, last});
        check("ar_ready_busy", {63'd0, axi_ar_ready_o}, 64'd0);
        for (int k = 0; k < bp; k++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, axi_r_valid_o}, 64'd1);
            check("bp_data",  axi_r_data_o, data);
            check("bp_last",  {63'd0, axi_r_last_o}, {63'd0, last});
            check("bp_mem_en", {63'd0, mem_en_o}, 64'd0);
        end
        axi_r_ready_i = 1'b1;
        @(posedge clk);
        #1 axi_r_ready_i = 1'b0;
    endtask

    task automatic check_idle();
        @(negedge clk);
        check("idle_ar_ready", {63'd0, axi_ar_ready_o}, 64'd1);
        check("idle_r_valid",  {63'd0, axi_r_valid_o},  64'd0);
    endtask

    initial begin
        reset          = 1'b1;
        axi_ar_valid_i = 1'b0;
        axi_ar_id_i    = '0;
        axi_ar_addr_i  = '0;
        axi_ar_len_i   = '0;
        axi_ar_size_i  = '0;
        axi_ar_burst_i = '0;
        axi_r_ready_i  = 1'b0;
        do_reset();

        // INCR single beat, sub-word start address.
        send_ar(4'd3, 64'h8000_0004, 8'd0, 3'd2, 2'b01);
        wait_beat(1'b1, 64'h8000_0000, 64'h1122_3344_5566_7788, 4'd3, 2'b00, 1'b1, 0);
        check_idle();

        // INCR 4 beats, 5 cycles of backpressure on beat 2.
        send_ar(4'd9, 64'h8000_0000, 8'd3, 3'd3, 2'b01);
        wait_beat(1'b1, 64'h8000_0000, mem_word(64'h8000_0000), 4'd9, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h8000_0008, mem_word(64'h8000_0008), 4'd9, 2'b00, 1'b0, 5);
        wait_beat(1'b1, 64'h8000_0010, mem_word(64'h8000_0010), 4'd9, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h8000_0018, mem_word(64'h8000_0018), 4'd9, 2'b00, 1'b1, 0);
        check_idle();

        // WRAP is rejected: two SLVERR beats, zero data, no memory access.
        send_ar(4'd1, 64'h40, 8'd1, 3'd3, 2'b10);
        wait_beat(1'b0, 64'h0, 64'h0, 4'd1, 2'b10, 1'b0, 0);
        wait_beat(1'b0, 64'h0, 64'h0, 4'd1, 2'b10, 1'b1, 0);
        check_idle();

        // FIXED: the same word three times.
        send_ar(4'd2, 64'h100, 8'd2, 3'd3, 2'b00);
        wait_beat(1'b1, 64'h100, mem_word(64'h100), 4'd2, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h100, mem_word(64'h100), 4'd2, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h100, mem_word(64'h100), 4'd2, 2'b00, 1'b1, 0);
        check_idle();

        // Oversized beat (size 4) is an error burst.
        send_ar(4'd4, 64'h2000, 8'd0, 3'd4, 2'b01);
        wait_beat(1'b0, 64'h0, 64'h0, 4'd4, 2'b10, 1'b1, 0);
        check_idle();

        // INCR size 2 from 0x1004: beats at 0x1004, 0x1008, 0x100C.
        send_ar(4'd6, 64'h1004, 8'd2, 3'd2, 2'b01);
        wait_beat(1'b1, 64'h1000, mem_word(64'h1000), 4'd6, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h1008, mem_word(64'h1008), 4'd6, 2'b00, 1'b0, 0);
        wait_beat(1'b1, 64'h1008, mem_word(64'h1008), 4'd6, 2'b00, 1'b1, 0);
        check_idle();

        // Reset during MWAIT of beat 2 aborts the burst.
        send_ar(4'd7, 64'h300, 8'd3, 3'd3, 2'b01);
        wait_beat(1'b1, 64'h300, mem_word(64'h300), 4'd7, 2'b00, 1'b0, 0);
        exp_q.push_back(64'h308);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("abort_r_valid",  {63'd0, axi_r_valid_o},  64'd0);
        check("abort_ar_ready", {63'd0, axi_ar_ready_o}, 64'd1);
        check("abort_mem_en",   {63'd0, mem_en_o},       64'd0);
        check("abort_r_last",   {63'd0, axi_r_last_o},   64'd0);
        check("abort_q_empty",  64'(exp_q.size()),       64'd0);
        send_ar(4'd5, 64'h200, 8'd0, 3'd3, 2'b01);
        wait_beat(1'b1, 64'h200, mem_word(64'h200), 4'd5, 2'b00, 1'b1, 0);
        check_idle();
        repeat (4) begin
            @(negedge clk);
            check("quiet_r_valid", {63'd0, axi_r_valid_o}, 64'd0);
        end

        check("exp_q_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_axi_r_slave.md
YSYX_22041071_AXI_R_SLAVE -- requirements
Module: ysyx_22041071_axi_r_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, AXI/memory address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, R data and memory word width.
REQ-003 SHALL have parameter ID_WIDTH, default 4, AR/R ID width.
REQ-004 SHALL have one clock and synchronous active-high reset, ports as follows:
- clk  in  1  sole clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- axi_ar_valid_i  in  1  AR valid.
- axi_ar_ready_o  out  1  AR ready.
- axi_ar_id_i  in  ID_WIDTH  AR ID.
- axi_ar_addr_i  in  ADDR_WIDTH  AR start byte address.
- axi_ar_len_i  in  8  beats minus one.
- axi_ar_size_i  in  3  bytes per beat, log2.
- axi_ar_burst_i  in  2  00 FIXED, 01 INCR, 10 WRAP.
- axi_r_valid_o  out  1  R valid.
- axi_r_ready_i  in  1  R ready.
- axi_r_id_o  out  ID_WIDTH  R ID.
- axi_r_data_o  out  DATA_WIDTH  R data, full aligned word.
- axi_r_resp_o  out  2  00 OKAY, 10 SLVERR.
- axi_r_last_o  out  1  final beat.
- axi_r_user_o  out  1  tied 0.
- mem_en_o  out  1  memory read strobe.
- mem_addr_o  out  ADDR_WIDTH  memory word address, low 3 bits 0.
- mem_rdata_i  in  DATA_WIDTH  memory data, valid exactly one cycle after mem_en_o.

Function
REQ-005 SHALL implement FSM IDLE, MREQ, MWAIT, RESP; one outstanding burst only.
REQ-006 SHALL drive axi_ar_ready_o = 1 only in IDLE, decoded from state register, with no combinational path from any input.
REQ-007 SHALL, on AR handshake in IDLE, latch id, addr, len, size, burst, clear beat counter, and go to MREQ.
REQ-008 SHALL flag the burst as error when burst = 10 or 11, or size > 3; the flag is latched with the AR.
REQ-009 SHALL, in MREQ, assert mem_en_o for exactly one cycle with mem_addr_o = {beat_addr[ADDR_WIDTH-1:3], 3'b000}, then go to MWAIT; on an error burst, mem_en_o SHALL stay 0.
REQ-010 SHALL, in MWAIT, register mem_rdata_i into axi_r_data_o (0 on error burst), then go to RESP.
REQ-011 SHALL, in RESP, hold axi_r_valid_o = 1 with data, id, resp and last stable until axi_r_ready_i = 1.
REQ-012 SHALL set axi_r_last_o = 1 iff beat counter equals latched len.
REQ-013 SHALL drive axi_r_resp_o = 10 on every beat of an error burst and 00 otherwise; beat count is len+1 in both cases.
REQ-014 SHALL, on R handshake with last, go to IDLE; otherwise increment the beat counter, advance the beat address and go to MREQ.
REQ-015 SHALL compute the next beat address as follows:
- INCR: (beat_addr aligned down to 2^size) + 2^size, modulo 2^ADDR_WIDTH.
- FIXED: unchanged.
REQ-016 SHALL return the whole aligned word unmasked; lane selection belongs to the master.
REQ-017 SHALL not check 4 KB boundaries.
REQ-018 Latency: AR handshake ends cycle t; mem_en_o = 1 in t+1; first axi_r_valid_o = 1 in t+3; each following beat valid 3 cycles after the previous R handshake.
REQ-019 SHALL ignore axi_ar_valid_i outside IDLE and axi_r_ready_i outside RESP.
REQ-020 axi_r_user_o SHALL be constant 0.

Reset
REQ-021 While reset = 1 at a clock edge, the block SHALL take the following values on the next cycle:
- state IDLE.
- axi_ar_ready_o 1.
- axi_r_valid_o, axi_r_last_o, mem_en_o 0.
- axi_r_data_o, axi_r_id_o, axi_r_resp_o, mem_addr_o, beat counter all 0.
REQ-022 Reset mid-burst SHALL abort the burst without further R beats; the first AR after reset SHALL be served normally.

Verification
REQ-023 INCR single beat: addr 0x8000_0004, len 0, size 2, id 3, mem word 0x1122334455667788 -> mem_addr 0x8000_0000 at t+1; R at t+3 with data 0x1122334455667788, id 3, resp 00, last 1.
REQ-024 INCR 4 beats: addr 0x8000_0000, len 3, size 3 -> mem_addr 0x...00, 08, 10, 18; last only on beat 4; ready returns to 1 the cycle after.
REQ-025 R backpressure: axi_r_ready_i low 5 cycles in RESP -> valid, data and last stay stable; no mem_en_o; advance the cycle after ready.
REQ-026 Error: burst 10, len 1 -> 2 beats, resp 10, data 0, mem_en_o never 1; FIXED len 2, addr 0x100 -> 3 reads of 0x100.
REQ-027 Reset asserted during MWAIT of beat 2 of len 3 -> next cycle valid 0, ready 1; new AR addr 0x200 len 0 completes normally in 3 cycles.
